// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: a bank of WIDTH JK cells driven by a small command
// sequencer. Commands are CLEAR, LOAD, COUNT (binary +1 steps) and SHIFT
// (left shift with serial-in). Each step is applied purely through the J/K
// drives, so the bank always obeys the JK table at every clock edge.
module jk_bank_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [7:0]       cmd_len,
    input  logic             abort,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             carry
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_COUNT = 2'b10;
    localparam logic [1:0] OP_SHIFT = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             aborted_q, aborted_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] j_drv, k_drv;
    logic [WIDTH-1:0] low_ones;   // low_ones[i] = AND of Q[i-1:0]; bit 0 is 1
    logic             stepping;   // a real step is applied at the closing edge
    logic             multi_op;   // COUNT or SHIFT (len-driven commands)
    logic             last_cycle; // this EXEC cycle ends the command

    // Per-cell drive: which cells must toggle for +1, and the shifted pattern.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case/if leaves it unassigned and no latch is inferred.
        j_drv       = '0;
        k_drv       = '0;
        low_ones    = '0;
        low_ones[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            low_ones[i] = low_ones[i-1] & q_q[i-1];
        end

        multi_op = (op_q == OP_COUNT) || (op_q == OP_SHIFT);
        stepping = (state_q == ST_EXEC) && !abort && !(multi_op && (len_q == 8'd0));

        if (stepping) begin
            unique case (op_q)
                OP_CLEAR: begin
                    j_drv = '0;
                    k_drv = '1;
                end
                OP_LOAD: begin
                    j_drv = data_q;
                    k_drv = ~data_q;
                end
                OP_COUNT: begin
                    j_drv = low_ones;
                    k_drv = low_ones;
                end
                OP_SHIFT: begin
                    j_drv = {q_q[WIDTH-2:0], data_q[0]};
                    k_drv = ~{q_q[WIDTH-2:0], data_q[0]};
                end
                default: ;
            endcase
        end
    end

    // Next-state logic: command accept, step counting, abort and wrap detect.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
        carry_d   = 1'b0;
        // Standard JK characteristic: set where J, keep where not K.
        q_d       = (j_drv & ~q_q) | (~k_drv & q_q);

        // CLEAR/LOAD and len=0 finish in one EXEC cycle; otherwise the
        // cycle applying step number len is the last one.
        last_cycle = !multi_op || (len_q == 8'd0) || ((cnt_q + 8'd1) == len_q);

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    data_d    = cmd_data;
                    len_d     = cmd_len;
                    cnt_d     = 8'd0;
                    aborted_d = 1'b0;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    if (stepping) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    carry_d = stepping && (op_q == OP_COUNT) && (&q_q);
                    if (last_cycle) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that wins over any command.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (Rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            data_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            q_q       <= '0;
            aborted_q <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            aborted_q <= aborted_d;
            carry_q   <= carry_d;
        end
    end

    assign J         = j_drv;
    assign K         = k_drv;
    assign Q         = q_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_EXEC);
    assign done      = (state_q == ST_DONE);
    assign aborted   = (state_q == ST_DONE) && aborted_q;
    assign carry     = carry_q;

endmodule

// File: doc/jk_bank_sequencer.md
JK_BANK_SEQUENCER -- requirements
Module: jk_bank_sequencer

Interface
REQ-001 The block SHALL have exactly one parameter: WIDTH, default 8, the number of JK cells in the bank (legal range 2..16).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- Clk  input  1  sole clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  the sequencer can accept a command.
- cmd_op  input  2  operation code: 00 CLEAR, 01 LOAD, 10 COUNT, 11 SHIFT.
- cmd_data  input  WIDTH  LOAD value; bit 0 is the SHIFT serial-in bit.
- cmd_len  input  8  step count for COUNT and SHIFT.
- abort  input  1  stop the current command.
- J  output  WIDTH  per-cell J drive applied this cycle.
- K  output  WIDTH  per-cell K drive applied this cycle.
- Q  output  WIDTH  bank state.
- busy  output  1  a command is in progress.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  qualifies done; high when the command was aborted.
- carry  output  1  one-cycle pulse on a COUNT wrap.
REQ-003 Clock and reset are decided: one clock, Clk; reset Rst is synchronous and active-high.

Function
REQ-004 Each bank cell SHALL follow the standard JK table at every Clk edge: J=0,K=0 holds; J=0,K=1 clears; J=1,K=0 sets; J=1,K=1 toggles.
REQ-005 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-006 cmd_ready SHALL be 1 only in IDLE, and busy SHALL be 1 only in EXEC.
REQ-007 A command SHALL be accepted on an edge where cmd_valid and cmd_ready are both 1; on that edge the block latches op, data and len, clears the step counter, and enters EXEC.
REQ-008 In IDLE and DONE, J and K SHALL be all zeros, so Q holds.
REQ-009 In EXEC, J and K SHALL be combinational from the latched op and the current Q, and one step is applied per EXEC cycle at its closing edge.
REQ-010 CLEAR SHALL take one step, with J=0 and K=all ones.
REQ-011 LOAD SHALL take one step, with J=data and K=~data.
REQ-012 COUNT SHALL take len steps, each a binary +1 with J[i]=K[i]=AND(Q[i-1:0]) and J[0]=K[0]=1.
REQ-013 SHIFT SHALL take len steps, each a left shift: J[i]=Q[i-1] and K[i]=~Q[i-1] for i>0; J[0]=data[0] and K[0]=~data[0].
REQ-014 After the edge that applies the last step, the state SHALL be DONE; DONE lasts exactly one cycle with done=1, then the state returns to IDLE.
REQ-015 COUNT or SHIFT with len=0 SHALL go from EXEC to DONE after one EXEC cycle, with J=K=0 and Q unchanged.
REQ-016 Latency SHALL be: accept edge, then steps EXEC cycles, then 1 DONE cycle, then back in IDLE; the minimum command period is steps+2 cycles.
REQ-017 A COUNT step from all ones SHALL wrap to zero, and carry SHALL be 1 for the cycle after that edge.
REQ-018 carry SHALL be 0 at all other times, including during LOAD, SHIFT and CLEAR.
REQ-019 The step counter SHALL be 8 bits; len=255 yields exactly 255 steps, with no counter overflow.
REQ-020 abort SHALL be sampled only in EXEC; when it is 1 at an edge, that edge applies no step (J=K=0 are driven in that cycle), the state goes to DONE, and aborted=1 together with done.
REQ-021 abort SHALL be ignored in IDLE and DONE.
REQ-022 cmd_valid while not ready SHALL be ignored; the command is not queued and the source must hold it until it is accepted.
REQ-023 cmd_op, cmd_data and cmd_len SHALL be ignored outside the accept edge.

Reset
REQ-024 Rst=1 at an edge SHALL force: state IDLE, Q=0, done=0, aborted=0, carry=0, step counter=0, and latched op/data/len=0.
REQ-025 Rst SHALL override any accept, step or abort at the same edge, including a reset in the middle of EXEC.
REQ-026 After reset, cmd_ready=1, busy=0 and J=K=0.

Verification
REQ-027 Scenario: reset, then LOAD data=0xA5 -> Q=0xA5 one edge after accept, done high the next cycle, cmd_ready high one cycle later.
REQ-028 Scenario: LOAD 0xFE, then COUNT len=3 -> Q goes 0xFF, 0x00, 0x01; carry pulses once, after the 0xFF->0x00 edge.
REQ-029 Scenario: LOAD 0x81, then SHIFT len=2 with data[0]=1 -> Q goes 0x03, then 0x07; each step shows J[0]=1 and K[0]=0.
REQ-030 Scenario: COUNT len=10 from 0 with abort high in the 4th EXEC cycle -> Q=0x03, done=1 and aborted=1 together, no further steps.
REQ-031 Scenario: COUNT len=0 -> exactly one busy cycle, Q unchanged, done=1 and aborted=0.
REQ-032 Scenario: Rst asserted mid-COUNT (len=20) -> Q=0x00 and cmd_ready=1 after the reset edge, and no done pulse.
